// File: rtl/parity_tx.sv
// parity_tx: 4-bit word serializer with an even-parity bit.
// Frame: start(0), data[0..3] LSB first, parity, stop(1). Each bit lasts CLKS_PER_BIT clocks.
// Optional macro PARITY_TX_FORCE_ERR_EN adds the force_err input, which inverts
// the parity for a single frame. Without the macro the parity is always even.
module parity_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef PARITY_TX_FORCE_ERR_EN
    input  logic       force_err,
`endif
    input  logic [3:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd,
    output logic       pbit,
    output logic       busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] shreg_q, shreg_d;
    logic       pbit_q, pbit_d;
    logic       txd_q, txd_d;
    logic       bit_end;
    logic       flip;

`ifdef PARITY_TX_FORCE_ERR_EN
    assign flip = force_err;
`else
    assign flip = 1'b0;
`endif

    assign bit_end = (cnt_q == LAST_CNT);

    // ready depends only on the state register, so a producer may legally
    // wait for ready before raising valid without forming a combinational loop.
    assign ready = (state_q == S_IDLE);
    assign busy  = (state_q != S_IDLE);
    assign txd   = txd_q;
    assign pbit  = pbit_q;

    // Next-state logic: advance the bit timer and step through the frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pbit_d  = pbit_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = 8'd0;
                idx_d = 2'd0;
                if (valid) begin
                    state_d = S_START;
                    shreg_d = data;
                    pbit_d  = (^data) ^ flip;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = 8'd0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = 8'd0;
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = S_PARITY;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        shreg_d = {1'b0, shreg_q[3:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = 8'd0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
                idx_d   = 2'd0;
            end
        endcase
    end

    // The line level is decoded from the next state, so txd is registered and
    // drops low on the acceptance edge itself, with no extra cycle of delay.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shreg_d[0];
            S_PARITY: txd_d = pbit_d;
            default:  txd_d = 1'b1;
        endcase
    end

    // State registers; an asynchronous reset aborts any frame and idles the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 2'd0;
            shreg_q <= 4'd0;
            pbit_q  <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            pbit_q  <= pbit_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx with CLKS_PER_BIT=4. Expected frames are
// hand-written, in transmission order: the MSB of each 7-bit constant is the start bit.
module tb_parity_tx;

    logic       clk;
    logic       rst_n;
    logic [3:0] data;
    logic       valid;
    logic       ready;
    logic       txd;
    logic       pbit;
    logic       busy;
`ifdef PARITY_TX_FORCE_ERR_EN
    logic       force_err;
`endif

    int n_vec;
    int n_err;

    parity_tx #(.CLKS_PER_BIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef PARITY_TX_FORCE_ERR_EN
        .force_err(force_err),
`endif
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .txd      (txd),
        .pbit     (pbit),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Present a word at a negedge while idle; it is accepted on the next posedge.
    task automatic send(input logic [3:0] d, input bit keep_valid);
        @(negedge clk);
        check_eq("ready_before_accept", {31'd0, ready}, 32'd1);
        check_eq("txd_idle", {31'd0, txd}, 32'd1);
        data  = d;
        valid = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) valid = 1'b0;
    endtask

    // Check the 28 frame cycles; optionally disturb data/valid during the DATA bits.
    task automatic run_frame(input logic [6:0] frame, input logic exp_p, input bit disturb);
        logic [6:0] f;
        f = frame;
        for (int b = 0; b < 7; b++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                check_eq("txd_bit", {31'd0, txd}, {31'd0, f[6-b]});
                check_eq("busy_frame", {31'd0, busy}, 32'd1);
                check_eq("ready_frame", {31'd0, ready}, 32'd0);
                if (b == 0 && c == 0)
                    check_eq("pbit", {31'd0, pbit}, {31'd0, exp_p});
                if (disturb && b == 2 && c == 1) begin
                    data  = ~data;
                    valid = 1'b1;
                end
                if (disturb && b == 4 && c == 0)
                    valid = 1'b0;
            end
        end
    endtask

    task automatic idle_check(input logic exp_p);
        @(negedge clk);
        check_eq("busy_idle", {31'd0, busy}, 32'd0);
        check_eq("ready_idle", {31'd0, ready}, 32'd1);
        check_eq("txd_idle_after", {31'd0, txd}, 32'd1);
        check_eq("pbit_hold", {31'd0, pbit}, {31'd0, exp_p});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        data  = 4'd0;
        valid = 1'b0;
`ifdef PARITY_TX_FORCE_ERR_EN
        force_err = 1'b0;
`endif
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        check_eq("rst_txd", {31'd0, txd}, 32'd1);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, ready}, 32'd1);
        check_eq("rst_pbit", {31'd0, pbit}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1011: frame 0,1,1,0,1,1,1 with parity 1.
        send(4'b1011, 1'b0);
        run_frame(7'b0110111, 1'b1, 1'b0);
        idle_check(1'b1);

        // 0000 gives parity 0; 1111 also gives parity 0.
        send(4'b0000, 1'b0);
        run_frame(7'b0000001, 1'b0, 1'b0);
        idle_check(1'b0);
        send(4'b1111, 1'b0);
        run_frame(7'b0111101, 1'b0, 1'b0);
        idle_check(1'b0);

        // Back-to-back with valid held high: 3 then 8, one idle cycle between.
        send(4'h3, 1'b1);
        data = 4'h8;
        run_frame(7'b0110001, 1'b0, 1'b0);
        send(4'h8, 1'b0);
        run_frame(7'b0000111, 1'b1, 1'b0);
        idle_check(1'b1);

        // Disturb data/valid mid-frame; the frame in flight must be unaffected.
        send(4'h5, 1'b0);
        run_frame(7'b0101001, 1'b0, 1'b1);
        idle_check(1'b0);

        // Reset in the middle of DATA aborts the frame without a clock edge.
        send(4'h9, 1'b0);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_txd", {31'd0, txd}, 32'd1);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_ready", {31'd0, ready}, 32'd1);
        check_eq("midrst_pbit", {31'd0, pbit}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // First posedge after release accepts 6: frame 0,0,1,1,0,0,1.
        data  = 4'h6;
        valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        run_frame(7'b0011001, 1'b0, 1'b0);
        idle_check(1'b0);

`ifdef PARITY_TX_FORCE_ERR_EN
        // Forced parity error on one frame, then a clean frame.
        force_err = 1'b1;
        send(4'b1011, 1'b0);
        force_err = 1'b0;
        run_frame(7'b0110101, 1'b0, 1'b0);
        idle_check(1'b0);
        send(4'b1011, 1'b0);
        run_frame(7'b0110111, 1'b1, 1'b0);
        idle_check(1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
